// File: rtl/branch_sequencer_pkg.sv
// branch_sequencer_pkg: shared definitions for the multi-cycle branch unit.
//   - cw_t: 33-bit control word; field order fixes the bit positions (MSB first)
//   - CW_NOP: idle control word
//   - pc_fs / alu_fs encodings, opcode class patterns, FSM state and cond codes
//   - decode_cls(): maps opcode bits I[31:21] to a branch class
package branch_sequencer_pkg;

  localparam int CW_W = 33;

  // Bit positions inside cw[32:0]:
  // alu_en 32 | alu_bs 31 | alu_fs 30:26 | rf_b_en 25 | rf_sa 24:20 | rf_sb 19:15
  // rf_da 14:10 | rf_w 9 | ram_en 8 | ram_w 7 | pc_en 6 | pc_fs 5:4 | pc_is 3
  // status_ld 2 | next_state 1:0
  typedef struct packed {
    logic       alu_en;
    logic       alu_bs;
    logic [4:0] alu_fs;
    logic       rf_b_en;
    logic [4:0] rf_sa;
    logic [4:0] rf_sb;
    logic [4:0] rf_da;
    logic       rf_w;
    logic       ram_en;
    logic       ram_w;
    logic       pc_en;
    logic [1:0] pc_fs;
    logic       pc_is;
    logic       status_ld;
    logic [1:0] next_state;
  } cw_t;

  localparam logic [4:0] ALU_FS_NOP    = 5'b11111;
  localparam logic [4:0] ALU_FS_ADD_ZB = 5'b01010;  // A + 0: passes Rt so Zalu reflects it

  localparam logic [1:0] PC_FS_HOLD = 2'b00;
  localparam logic [1:0] PC_FS_INC  = 2'b01;
  localparam logic [1:0] PC_FS_REL  = 2'b10;
  localparam logic [1:0] PC_FS_LOAD = 2'b11;

  localparam cw_t CW_NOP = '{alu_fs: ALU_FS_NOP, rf_sb: 5'd31, default: '0};

  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [5:0]  OP_BL    = 6'b100101;
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  localparam logic [10:0] OP_BR    = 11'b11010110000;

  typedef enum logic [2:0] {
    CLS_NONE, CLS_B, CLS_BL, CLS_CBZ, CLS_CBNZ, CLS_BCOND, CLS_BR
  } br_cls_t;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LINK = 3'd1;
  localparam logic [2:0] ST_TEST = 3'd2;
  localparam logic [2:0] ST_TAKE = 3'd3;
  localparam logic [2:0] ST_SKIP = 3'd4;

  localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_HS = 4'h2, COND_LO = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF;

  function automatic br_cls_t decode_cls(input logic [10:0] op);
    br_cls_t c;
    c = CLS_NONE;
    if (op == OP_BR)               c = CLS_BR;
    else if (op[10:3] == OP_CBZ)   c = CLS_CBZ;
    else if (op[10:3] == OP_CBNZ)  c = CLS_CBNZ;
    else if (op[10:3] == OP_BCOND) c = CLS_BCOND;
    else if (op[10:5] == OP_B)     c = CLS_B;
    else if (op[10:5] == OP_BL)    c = CLS_BL;
    return c;
  endfunction

endpackage

// File: rtl/branch_sequencer_cond_eval.sv
// branch_cond_eval: combinational B.cond evaluator.
//   cond   - condition code I[3:0]
//   flags  - {V,C,N,Z}
//   result - 1 when the condition holds
module branch_cond_eval
  import branch_sequencer_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       result
);
  logic v, c, n, z;
  assign {v, c, n, z} = flags;

  always_comb begin
    result = 1'b1;
    case (cond)
      COND_EQ: result = z;
      COND_NE: result = ~z;
      COND_HS: result = c;
      COND_LO: result = ~c;
      COND_MI: result = n;
      COND_PL: result = ~n;
      COND_VS: result = v;
      COND_VC: result = ~v;
      COND_HI: result = c & ~z;
      COND_LS: result = ~(c & ~z);
      COND_GE: result = (n == v);
      COND_LT: result = (n != v);
      COND_GT: result = ~z & (n == v);
      COND_LE: result = ~(~z & (n == v));
      default: result = 1'b1;  // AL / NV
    endcase
  end
endmodule

// File: rtl/branch_sequencer.sv
// branch_sequencer: multi-cycle branch unit (B, BL, CBZ, CBNZ, B.cond, BR).
//   clock/reset  - rising-edge clock, async active-high reset
//   start, I     - instruction request, accepted only while ready
//   status       - {V,C,N,Z,Zalu}; Zalu is this cycle's ALU zero
//   ready        - FSM idle
//   cw, K        - control word and byte branch offset for the current step
//   done, taken  - PC-update cycle and whether the PC was redirected
//   illegal      - pulse one cycle after start with a non-branch opcode
//   taken_count  - saturating count of taken branches
module branch_sequencer
  import branch_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int LINK_REG   = 30,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           I,
  input  logic [4:0]            status,
  output logic                  ready,
  output logic [CW_W-1:0]       cw,
  output logic [DATA_WIDTH-1:0] K,
  output logic                  done,
  output logic                  taken,
  output logic                  illegal,
  output logic [CNT_WIDTH-1:0]  taken_count
);
  logic [2:0]           state_q, state_d;
  logic [31:0]          ir_q;
  logic [3:0]           flags_q;
  logic                 illegal_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  br_cls_t              cls_in, cls_q;
  logic                 idle, accept, cond_true, cbx_take;
  logic [3:0]           cond_sel, flags_sel;
  cw_t                  cw_c;

  assign idle   = (state_q == ST_IDLE);
  assign cls_in = decode_cls(I[31:21]);
  assign cls_q  = decode_cls(ir_q[31:21]);
  assign accept = idle & start & (cls_in != CLS_NONE);

  // B.cond is resolved at accept time from the live flags (the same value that
  // is captured into flags_q). Once a sequence is running the evaluator looks at
  // the captured operands, so cond_true stays tied to the accepted instruction.
  assign cond_sel  = idle ? I[3:0]      : ir_q[3:0];
  assign flags_sel = idle ? status[4:1] : flags_q;

  branch_cond_eval u_cond (
    .cond   (cond_sel),
    .flags  (flags_sel),
    .result (cond_true)
  );

  assign cbx_take = (cls_q == CLS_CBZ) ? status[0] : ~status[0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:
        if (accept) begin
          case (cls_in)
            CLS_BL:            state_d = ST_LINK;
            CLS_CBZ, CLS_CBNZ: state_d = ST_TEST;
            CLS_BCOND:         state_d = cond_true ? ST_TAKE : ST_SKIP;
            default:           state_d = ST_TAKE;
          endcase
        end
      ST_LINK: state_d = ST_TAKE;
      ST_TEST: state_d = cbx_take ? ST_TAKE : ST_SKIP;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ir_q      <= '0;
      flags_q   <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= idle & start & (cls_in == CLS_NONE);
      if (accept) begin
        ir_q    <= I;
        flags_q <= status[4:1];
      end
      if (state_q == ST_TAKE && !(&cnt_q)) cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    cw_c = CW_NOP;
    case (state_q)
      ST_LINK: begin
        cw_c       = '0;
        cw_c.pc_en = 1'b1;  // PC+4 onto the bus for the link write
        cw_c.rf_da = 5'(LINK_REG);
        cw_c.rf_w  = 1'b1;
      end
      ST_TEST: begin
        cw_c        = '0;
        cw_c.rf_sa  = ir_q[4:0];
        cw_c.alu_fs = ALU_FS_ADD_ZB;
      end
      ST_TAKE: begin
        cw_c = '0;
        if (cls_q == CLS_BR) begin
          cw_c.rf_sb   = ir_q[9:5];
          cw_c.rf_b_en = 1'b1;
          cw_c.pc_fs   = PC_FS_LOAD;
        end else begin
          cw_c.pc_fs = PC_FS_REL;
          cw_c.pc_is = 1'b1;
        end
      end
      ST_SKIP: begin
        cw_c       = '0;
        cw_c.pc_fs = PC_FS_INC;
      end
      default: cw_c = CW_NOP;
    endcase
  end

  always_comb begin
    K = '0;
    if (!idle) begin
      case (cls_q)
        CLS_B, CLS_BL:
          K = {{(DATA_WIDTH-28){ir_q[25]}}, ir_q[25:0], 2'b00};
        CLS_CBZ, CLS_CBNZ, CLS_BCOND:
          K = {{(DATA_WIDTH-21){ir_q[23]}}, ir_q[23:5], 2'b00};
        default: K = '0;
      endcase
    end
  end

  assign cw          = cw_c;
  assign ready       = idle;
  assign done        = (state_q == ST_TAKE) || (state_q == ST_SKIP);
  assign taken       = (state_q == ST_TAKE);
  assign illegal     = illegal_q;
  assign taken_count = cnt_q;
endmodule

// File: tb/tb_branch_sequencer.sv
module tb_branch_sequencer;
  logic        clock = 1'b0;
  logic        reset, start;
  logic [31:0] I;
  logic [4:0]  status;
  logic        ready, done, taken, illegal;
  logic [32:0] cw;
  logic [63:0] K;
  logic [15:0] taken_count;
  // narrow-counter instance shares all inputs
  logic        ready2, done2, taken2, illegal2;
  logic [32:0] cw2;
  logic [63:0] K2;
  logic [1:0]  taken_count2;

  int n_cmp = 0, n_bad = 0;
  int exp_cnt = 0, exp_cnt2 = 0;

  always #5 clock = ~clock;

  branch_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .I(I), .status(status),
    .ready(ready), .cw(cw), .K(K), .done(done), .taken(taken),
    .illegal(illegal), .taken_count(taken_count)
  );

  branch_sequencer #(.CNT_WIDTH(2)) dut2 (
    .clock(clock), .reset(reset), .start(start), .I(I), .status(status),
    .ready(ready2), .cw(cw2), .K(K2), .done(done2), .taken(taken2),
    .illegal(illegal2), .taken_count(taken_count2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // control word assembled from named fields; unlisted fields are zero
  function automatic logic [32:0] mk_cw(input logic [4:0] alu_fs, input logic rf_b_en,
      input logic [4:0] rf_sa, input logic [4:0] rf_sb, input logic [4:0] rf_da,
      input logic rf_w, input logic pc_en, input logic [1:0] pc_fs, input logic pc_is);
    return {1'b0, 1'b0, alu_fs, rf_b_en, rf_sa, rf_sb, rf_da, rf_w,
            1'b0, 1'b0, pc_en, pc_fs, pc_is, 1'b0, 2'b00};
  endfunction

  // 0 none, 1 B, 2 BL, 3 CBZ, 4 CBNZ, 5 B.cond, 6 BR
  function automatic int m_cls(input logic [31:0] ins);
    if (ins[31:21] == 11'b11010110000) return 6;
    if (ins[31:24] == 8'b10110100)     return 3;
    if (ins[31:24] == 8'b10110101)     return 4;
    if (ins[31:24] == 8'b01010100)     return 5;
    if (ins[31:26] == 6'b000101)       return 1;
    if (ins[31:26] == 6'b100101)       return 2;
    return 0;
  endfunction

  // flags = {V,C,N,Z}; odd codes below 14 are the negation of their pair
  function automatic logic m_cond(input logic [3:0] cond, input logic [3:0] f);
    logic v, c, n, z, b;
    {v, c, n, z} = f;
    case (cond[3:1])
      3'd0: b = z;
      3'd1: b = c;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = c && !z;
      3'd5: b = (n == v);
      3'd6: b = !z && (n == v);
      default: return 1'b1;
    endcase
    return b ^ cond[0];
  endfunction

  function automatic logic [63:0] m_k(input logic [31:0] ins, input int cls);
    logic signed [63:0] ks;
    if (cls == 1 || cls == 2) ks = $signed(ins[25:0]);
    else                      ks = $signed(ins[23:5]);
    return ks * 4;
  endfunction

  // Runs one instruction from IDLE to the return to IDLE; called at a negedge.
  task automatic run_instr(input logic [31:0] ins, input logic [3:0] flg, input logic zalu);
    int cls;
    logic tk;
    logic [63:0] k;
    logic [32:0] nop_cw, exp_cw;
    nop_cw = mk_cw(5'h1f, 0, 0, 5'd31, 0, 0, 0, 2'b00, 0);
    cls = m_cls(ins);
    chk("idle_ready", {63'd0, ready}, 64'd1);
    chk("idle_cw", {31'd0, cw}, {31'd0, nop_cw});
    I = ins; status = {flg, 1'($urandom)}; start = 1'b1;
    @(negedge clock);
    start = 1'b0; I = $urandom; status = 5'($urandom);
    if (cls == 0) begin
      chk("illegal_pulse", {63'd0, illegal}, 64'd1);
      chk("illegal_ready", {63'd0, ready}, 64'd1);
      chk("illegal_done", {63'd0, done}, 64'd0);
      @(negedge clock);
      chk("illegal_clear", {63'd0, illegal}, 64'd0);
      return;
    end
    chk("no_illegal", {63'd0, illegal}, 64'd0);
    k = m_k(ins, cls);
    tk = 1'b1;
    if (cls == 2) begin
      chk("link_cw", {31'd0, cw}, {31'd0, mk_cw(0, 0, 0, 0, 5'd30, 1, 1, 2'b00, 0)});
      chk("link_k", K, k);
      chk("link_done", {63'd0, done}, 64'd0);
      chk("link_ready", {63'd0, ready}, 64'd0);
      start = 1'b1; I = {8'b01010100, 24'($urandom)};  // must be ignored
      @(negedge clock);
      start = 1'b0;
    end else if (cls == 3 || cls == 4) begin
      chk("test_cw", {31'd0, cw}, {31'd0, mk_cw(5'b01010, 0, ins[4:0], 0, 0, 0, 0, 2'b00, 0)});
      chk("test_done", {63'd0, done}, 64'd0);
      status = {4'($urandom), zalu};
      @(negedge clock);
      tk = (cls == 3) ? zalu : !zalu;
    end else if (cls == 5) begin
      tk = m_cond(ins[3:0], flg);
    end
    if (!tk)           exp_cw = mk_cw(0, 0, 0, 0, 0, 0, 0, 2'b01, 0);
    else if (cls == 6) exp_cw = mk_cw(0, 1, 0, ins[9:5], 0, 0, 0, 2'b11, 0);
    else               exp_cw = mk_cw(0, 0, 0, 0, 0, 0, 0, 2'b10, 1);
    chk("done", {63'd0, done}, 64'd1);
    chk("taken", {63'd0, taken}, {63'd0, tk});
    chk("pc_cw", {31'd0, cw}, {31'd0, exp_cw});
    chk("pc_ready", {63'd0, ready}, 64'd0);
    if (cls != 6) chk("pc_k", K, k);
    start = 1'b1; I = {6'b000101, 26'($urandom)};  // start during done: ignored
    @(negedge clock);
    start = 1'b0;
    if (tk) begin
      if (exp_cnt < 65535) exp_cnt++;
      if (exp_cnt2 < 3) exp_cnt2++;
    end
    chk("back_idle", {63'd0, ready}, 64'd1);
    chk("back_nop", {31'd0, cw}, {31'd0, nop_cw});
    chk("back_done", {63'd0, done}, 64'd0);
    chk("count", {48'd0, taken_count}, 64'(exp_cnt));
    chk("count2", {62'd0, taken_count2}, 64'(exp_cnt2));
  endtask

  initial begin
    logic [3:0] pats [4];
    logic [31:0] ins;
    int c;
    pats[0] = 4'b1010; pats[1] = 4'b0001; pats[2] = 4'b0110; pats[3] = 4'b1101;
    reset = 1'b1; start = 1'b0; I = '0; status = '0;
    @(negedge clock);
    chk("rst_ready", {63'd0, ready}, 64'd1);
    chk("rst_cw", {31'd0, cw}, {31'd0, mk_cw(5'h1f, 0, 0, 5'd31, 0, 0, 0, 2'b00, 0)});
    chk("rst_k", K, 64'd0);
    chk("rst_flags", {61'd0, done, taken, illegal}, 64'd0);
    chk("rst_count", {48'd0, taken_count}, 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // directed cases
    run_instr({6'b000101, 26'h3FFFFFF}, 4'h0, 1'b0);            // B, K = -4
    chk("b_k_const", m_k({6'b000101, 26'h3FFFFFF}, 1), 64'hFFFF_FFFF_FFFF_FFFC);
    run_instr({6'b000101, 26'h2000000}, 4'h0, 1'b0);            // most-negative imm26
    run_instr({6'b100101, 26'd4}, 4'h0, 1'b0);                  // BL, K = 16
    run_instr({8'b10110100, 19'h12345, 5'd3}, 4'h0, 1'b1);      // CBZ taken
    run_instr({8'b10110101, 19'h00010, 5'd3}, 4'h0, 1'b1);      // CBNZ skip
    run_instr({8'b10110100, 19'h40000, 5'd9}, 4'h0, 1'b0);      // most-negative imm19, skip
    run_instr({8'b01010100, 19'd5, 1'b0, 4'hC}, 4'b1010, 1'b0); // GT taken
    run_instr({8'b01010100, 19'd5, 1'b0, 4'hB}, 4'b1010, 1'b0); // LT not taken
    run_instr({11'b11010110000, 11'b11111000000, 5'd7, 5'd0}, 4'h0, 1'b0); // BR Rn=7
    run_instr(32'h8B020020, 4'h0, 1'b0);                        // ADD -> illegal

    // cond sweep
    for (int cc = 0; cc < 16; cc++)
      for (int p = 0; p < 4; p++)
        run_instr({8'b01010100, 19'($urandom), 1'b0, 4'(cc)}, pats[p], 1'($urandom));

    // random mix
    for (int n = 0; n < 300; n++) begin
      c = $urandom_range(0, 6);
      ins = $urandom;
      case (c)
        1: ins[31:26] = 6'b000101;
        2: ins[31:26] = 6'b100101;
        3: ins[31:24] = 8'b10110100;
        4: ins[31:24] = 8'b10110101;
        5: begin ins[31:24] = 8'b01010100; ins[4] = 1'b0; end
        6: ins[31:21] = 11'b11010110000;
        default: if (m_cls(ins) != 0) ins[31:21] = 11'b10001011000;
      endcase
      run_instr(ins, 4'($urandom), 1'($urandom));
    end

    // reset while in LINK: immediate return to reset values, no done
    I = {6'b100101, 26'd8}; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("pre_rst_ready", {63'd0, ready}, 64'd0);
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", {63'd0, ready}, 64'd1);
    chk("mid_rst_cw", {31'd0, cw}, {31'd0, mk_cw(5'h1f, 0, 0, 5'd31, 0, 0, 0, 2'b00, 0)});
    chk("mid_rst_k", K, 64'd0);
    chk("mid_rst_flags", {61'd0, done, taken, illegal}, 64'd0);
    chk("mid_rst_count", {48'd0, taken_count}, 64'd0);
    chk("mid_rst_count2", {62'd0, taken_count2}, 64'd0);
    exp_cnt = 0; exp_cnt2 = 0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_done", {63'd0, done}, 64'd0);

    // saturation of the 2-bit counter
    for (int n = 0; n < 5; n++) run_instr({6'b000101, 26'($urandom)}, 4'h0, 1'b0);
    chk("sat_count2", {62'd0, taken_count2}, 64'd3);
    chk("sat_count", {48'd0, taken_count}, 64'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Multi-cycle branch unit for the control unit; handles B, BL, CBZ, CBNZ, B.cond and BR instead of the single-cycle unconditional-branch decode.
- Latches the instruction on `start` and steps a small FSM. Each cycle it emits the standard 33-bit control word plus constant K.
- Pulses `done` when the PC update is issued.
- Keeps a saturating count of taken branches for performance monitoring.

Parameters:
- DATA_WIDTH, 64, width of the K constant/datapath.
- LINK_REG, 30, register written by BL.
- CNT_WIDTH, 16, width of the taken-branch counter.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request to execute the instruction on I; accepted only when ready=1.
- I  in  32  instruction word.
- status  in  5  {V,C,N,Z,Zalu}; [4:1] are registered flags, [0] is the combinational ALU-zero of the current cycle.
- ready  out  1  high in IDLE only.
- cw  out  33  control word {alu_en, alu_bs, alu_fs[4:0], rf_b_en, rf_sa[4:0], rf_sb[4:0], rf_da[4:0], rf_w, ram_en, ram_w, pc_en, pc_fs[1:0], pc_is, status_ld, next_state[1:0]}.
- K  out  DATA_WIDTH  sign-extended branch offset, in bytes (immediate << 2).
- done  out  1  one-cycle pulse coinciding with the PC-update cycle.
- taken  out  1  valid with done; 1 = PC redirected.
- illegal  out  1  one-cycle pulse when start is given with a non-branch opcode.
- taken_count  out  CNT_WIDTH  saturating taken-branch counter.

Behaviour:
- Reset (asynchronous), all outputs at reset:
  - state=IDLE, latched instruction=0, taken_count=0.
  - done/taken/illegal=0, ready=1, cw=NOP, K=0.
- NOP cw: alu_fs=5'b11111, rf_sb=31, all other fields 0.
- Opcode classes from I[31:21]:
  - B: [31:26]=000101.
  - BL: [31:26]=100101.
  - CBZ: [31:24]=10110100.
  - CBNZ: [31:24]=10110101.
  - B.cond: [31:24]=01010100.
  - BR: [31:21]=11010110000.
  - imm26=I[25:0]; imm19=I[23:5]; Rt/cond=I[4:0]; Rn=I[9:5].
- IDLE:
  - Outputs NOP cw.
  - start with illegal class: illegal pulse next cycle, stay IDLE.
  - start with legal class: latch I, compute K, and sample status[4:1] into a flag register.
  - Next state by class: B/BR→TAKE; BL→LINK; CBZ/CBNZ→TEST; B.cond→TAKE if cond true, else SKIP.
- LINK (BL):
  - cw: pc_en=1 (PC+4 onto bus), rf_da=LINK_REG, rf_w=1.
  - → TAKE.
- TEST (CBZ/CBNZ):
  - cw: rf_sa=Rt, alu_bs=0, alu_fs=add with B zeroed (5'b01010).
  - Decision sampled from status[0] at the end of the cycle.
  - CBZ takes on status[0]=1; CBNZ takes on status[0]=0.
  - → TAKE or SKIP.
- TAKE:
  - B/BL/CBx/B.cond: pc_fs=2'b10 (PC+K), pc_is=1.
  - BR: rf_sb=Rn, rf_b_en=1, pc_fs=2'b11 (load), pc_is=0.
  - done=1, taken=1, taken_count+=1, saturating at all-ones.
  - → IDLE.
- SKIP:
  - pc_fs=2'b01 (PC+4); done=1, taken=0.
  - → IDLE.
- All non-NOP cw have next_state=2'b00 and status_ld=0.
- cw and K are combinational from state and latched instruction. done/taken/illegal are asserted during the output cycle.
- Latency (start cycle = 0):
  - B, BR, B.cond: done in cycle 1.
  - BL, CBZ, CBNZ: done in cycle 2.
- B.cond condition codes, evaluated on the sampled flags:
  - EQ Z; NE !Z; HS C; LO !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !(C&!Z); GE N==V; LT N!=V; GT !Z&(N==V); LE !(GT).
  - AL/NV (0xE/0xF) always true.
- Boundaries:
  - start while not IDLE is ignored.
  - start in the same cycle as done is ignored (ready=0).
  - Reset mid-sequence aborts without a done pulse.
  - Offset sign extension is exact for the most-negative imm26/imm19.

Decomposition:
- Shared package holds:
  - cw field widths and bit positions.
  - the NOP constant.
  - pc_fs and alu_fs encodings.
  - opcode class patterns.
  - state encoding (IDLE, LINK, TEST, TAKE, SKIP).
  - cond-code constants.
- One sub-module, branch_cond_eval: combinational cond[3:0] × flags → true.

Test Plan:
- B, imm26=26'h3FFFFFF, start → cycle 1: done=1, taken=1, K=64'hFFFF_FFFF_FFFF_FFFC, pc_fs=10, pc_is=1; taken_count=1.
- BL, imm26=4 → cycle 1: rf_w=1, rf_da=30, pc_en=1; cycle 2: done, K=16, taken=1.
- CBZ Rt=3, status[0]=1 in TEST → taken=1. Repeat with CBNZ, status[0]=1 → SKIP, pc_fs=01, taken=0, count unchanged.
- B.cond: GT with sampled {V,C,N,Z}=4'b1010 → taken. LT with the same flags → not taken. Sweep all 16 conds with 4 flag patterns against a reference model.
- BR Rn=7 → cycle 1: rf_sb=7, rf_b_en=1, pc_fs=11, pc_is=0, done=1.
- Robustness:
  - I=ADD opcode with start → illegal pulse, ready stays 1.
  - Reset asserted in LINK → outputs at reset values immediately, no done.
  - CNT_WIDTH=2 with 5 taken branches → taken_count=3.
